// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit
package fetch_pkg;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT} state_t;
  localparam int PC_STEP = 4;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 22;
  localparam int BR_OFF_W = 19;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: imem bus plus controller handshake of the fetch unit
interface instr_fetch_unit_if #(parameter int ADDR_W = 8);
  logic start;
  logic imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_rdata;
  logic imem_rvalid;
  logic [31:0] instruction;
  logic [9:0] opcode;
  logic instr_valid;
  logic instr_ready;
  logic branch;
  logic [18:0] branch_offset;
  logic [ADDR_W-1:0] pc;
  logic halted;
  modport master (
    input start, imem_rdata, imem_rvalid, instr_ready, branch, branch_offset,
    output imem_req, imem_addr, instruction, opcode, instr_valid, pc, halted
  );
  modport slave (
    output start, imem_rdata, imem_rvalid, instr_ready, branch, branch_offset,
    input imem_req, imem_addr, instruction, opcode, instr_valid, pc, halted
  );
endinterface

// File: rtl/fetch_pc_next.sv
// fetch_pc_next: sequential or branch-relative next PC, modulo 2^ADDR_W
module fetch_pc_next import fetch_pkg::*; #(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0]   pc,
  input  logic                branch,
  input  logic [BR_OFF_W-1:0] branch_offset,
  output logic [ADDR_W-1:0]   pc_next
);
  logic [31:0] ofs;
  // word offset sign-extended and scaled to bytes; the cast truncates to ADDR_W
  assign ofs = {{(32 - BR_OFF_W - 2){branch_offset[BR_OFF_W-1]}}, branch_offset, 2'b00};
  assign pc_next = ADDR_W'(32'(pc) + (branch ? ofs : 32'(PC_STEP)));
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches words from imem and hands them to the controller
module instr_fetch_unit import fetch_pkg::*; #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0] HALT_WORD = 32'h0
) (
  input logic clk,
  input logic rst,
  instr_fetch_unit_if.master bus
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_nxt;
  logic [31:0] instr_q, instr_d;
  fetch_pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc(pc_q),
    .branch(bus.branch),
    .branch_offset(bus.branch_offset),
    .pc_next(pc_nxt)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      IDLE: state_d = bus.start ? REQ : IDLE;
      REQ:  state_d = WAIT;
      WAIT:
        if (bus.imem_rvalid) begin
          instr_d = bus.imem_rdata;
          state_d = (bus.imem_rdata == HALT_WORD) ? HALT : HOLD;
        end
      HOLD:
        if (bus.instr_ready) begin
          pc_d    = pc_nxt;
          state_d = REQ;
        end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end
  assign bus.imem_req    = state_q == REQ;
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instruction = instr_q;
  assign bus.opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign bus.instr_valid = state_q == HOLD;
  assign bus.halted      = state_q == HALT;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed plus randomized fetch sequences checked against a PC/word model
module tb_instr_fetch_unit;
  logic clk = 0;
  logic rst = 0;
  int total = 0;
  int bad = 0;
  int mpc = 0;
  always #5 clk = ~clk;
  instr_fetch_unit_if #(.ADDR_W(8)) bus();
  instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'd0), .HALT_WORD(32'h0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_pc"}, bus.pc, 0);
    chk({tag, "_addr"}, bus.imem_addr, 0);
    chk({tag, "_instr"}, bus.instruction, 0);
    chk({tag, "_opc"}, bus.opcode, 0);
    chk({tag, "_ctl"}, {bus.instr_valid, bus.imem_req, bus.halted}, 0);
  endtask
  task automatic fetch(input int lat, input logic [31:0] word, input int hold,
                       input bit br, input int off, input bit spur);
    int n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("req", bus.imem_req, 1);
    chk("addr", bus.imem_addr, mpc);
    step();
    for (int i = 1; i < lat; i++) begin
      chk("wait_idle", {bus.instr_valid, bus.imem_req}, 0);
      step();
    end
    bus.imem_rvalid = 1;
    bus.imem_rdata = word;
    step();
    bus.imem_rvalid = 0;
    bus.imem_rdata = $urandom;
    if (word == 32'h0) begin
      chk("halted", {bus.halted, bus.instr_valid, bus.imem_req}, 3'b100);
      return;
    end
    chk("valid", bus.instr_valid, 1);
    chk("instr", bus.instruction, word);
    chk("opcode", bus.opcode, word >> 22);
    chk("pc", bus.pc, mpc);
    if (spur) begin
      bus.imem_rvalid = 1;
      bus.imem_rdata = ~word;
      step();
      bus.imem_rvalid = 0;
      chk("spur_instr", bus.instruction, word);
    end
    for (int i = 0; i < hold; i++) begin
      bus.branch = 1'($urandom);
      bus.branch_offset = 19'($urandom);
      bus.start = 1'($urandom);
      step();
      chk("hold_ctl", {bus.instr_valid, bus.imem_req, bus.pc}, {2'b10, 8'(mpc)});
      chk("hold_instr", bus.instruction, word);
    end
    bus.instr_ready = 1;
    bus.branch = br;
    bus.branch_offset = 19'(off);
    step();
    bus.instr_ready = 0;
    bus.start = 0;
    mpc = (mpc + (br ? off * 4 : 4)) & 255;
    chk("drop", bus.instr_valid, 0);
  endtask
  initial begin
    bus.start = 0;
    bus.imem_rdata = 0;
    bus.imem_rvalid = 0;
    bus.instr_ready = 0;
    bus.branch = 0;
    bus.branch_offset = 0;
    #2 rst = 1;
    #1 chk_reset("rst");
    step();
    rst = 0;
    bus.imem_rvalid = 1;
    bus.imem_rdata = 32'h1234_5678;
    step();
    step();
    bus.imem_rvalid = 0;
    chk_reset("stale");
    bus.start = 1;
    step();
    bus.start = 0;
    fetch(1, 32'h8A00_0000, 10, 0, 0, 0);
    fetch(2, 32'h1111_2222, 0, 0, 0, 0);
    fetch(1, 32'h3333_4444, 1, 1, -2, 0);
    fetch(1, 32'h5555_6666, 0, 1, 3, 0);
    fetch(1, 32'h7777_8888, 0, 1, 60, 0);
    chk("at_252", mpc, 252);
    fetch(3, 32'h9999_AAAA, 2, 0, 0, 1);
    fetch(1, 32'hBBBB_CCCC, 0, 1, 4, 0);
    chk("at_16", mpc, 16);
    fetch(1, 32'h0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      bus.start = 1'($urandom);
      bus.instr_ready = 1'($urandom);
      step();
      chk("halt_stay", {bus.halted, bus.instr_valid, bus.imem_req}, 3'b100);
    end
    bus.start = 0;
    bus.instr_ready = 0;
    #2 rst = 1;
    #1 chk_reset("halt_rst");
    step();
    rst = 0;
    mpc = 0;
    bus.start = 1;
    step();
    bus.start = 0;
    fetch(1, 32'hDEAD_BEEF, 0, 0, 0, 0);
    chk("pre_wait_req", {bus.imem_req, bus.imem_addr}, {1'b1, 8'd4});
    step();
    #2 rst = 1;
    #1 chk_reset("wait_rst");
    bus.imem_rvalid = 1;
    bus.imem_rdata = 32'hCAFE_F00D;
    step();
    rst = 0;
    step();
    bus.imem_rvalid = 0;
    chk_reset("wait_ign");
    mpc = 0;
    bus.start = 1;
    step();
    bus.start = 0;
    for (int k = 0; k < 40; k++) begin
      int lat = int'($urandom_range(1, 4));
      int hold = int'($urandom_range(0, 3));
      bit br = 1'($urandom);
      int off = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 524287)) - 262144
                                            : int'($urandom_range(0, 40)) - 20;
      logic [31:0] w = $urandom | 32'h1;
      fetch(lat, w, hold, br, off, 1'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
